// File: rtl/shift_unit_seq.sv
// shift_unit_seq: selects a shift amount, captures an operand, shifts it one bit per cycle
// Ports: clk/reset (sync, active-low); start/mode/sel/amt_in/data_in request a shift;
//        busy (SHIFT state), done (one-cycle pulse), result (held), shamt_used (last captured amount).
module shift_unit_seq #(
    parameter int DATA_W    = 32,
    parameter int SHAMT_W   = 5,
    parameter int N_SRC     = 3,
    parameter int CONST_AMT = 16,
    parameter int SEL_W     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_SRC*SHAMT_W-1:0] amt_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        result,
    output logic [SHAMT_W-1:0]       shamt_used
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [SHAMT_W-1:0] CONST_V = SHAMT_W'(CONST_AMT);
    localparam logic [SHAMT_W-1:0] ONE     = SHAMT_W'(1);
    state_t               state_q, state_d;
    logic [DATA_W-1:0]    work_q, work_d, result_q, result_d, shifted;
    logic [1:0]           mode_q, mode_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d, shamt_q, shamt_d, sel_amt;
    logic                 accept;
    // Selectors above N_SRC fall through to a zero amount.
    always_comb begin
        sel_amt = '0;
        for (int k = 0; k < N_SRC; k++)
            if (int'(sel) == k) sel_amt = amt_in[k*SHAMT_W +: SHAMT_W];
        if (int'(sel) == N_SRC) sel_amt = CONST_V;
    end
    assign shifted = mode_q == 2'b00 ? {work_q[DATA_W-2:0], 1'b0} :
                     mode_q == 2'b01 ? {1'b0, work_q[DATA_W-1:1]} :
                     mode_q == 2'b10 ? {work_q[DATA_W-1], work_q[DATA_W-1:1]} :
                                       {work_q[0], work_q[DATA_W-1:1]};
    // A request is accepted in IDLE or DONE, giving back-to-back operation.
    assign accept = start && state_q != SHIFT;
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        shamt_d  = shamt_q;
        if (accept) begin
            work_d  = data_in;
            mode_d  = mode;
            cnt_d   = sel_amt;
            shamt_d = sel_amt;
            state_d = sel_amt == '0 ? DONE : SHIFT;
            if (sel_amt == '0) result_d = data_in;
        end else if (state_q == SHIFT) begin
            work_d = shifted;
            cnt_d  = cnt_q - ONE;
            if (cnt_q == ONE) begin
                state_d  = DONE;
                result_d = shifted;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            mode_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            shamt_q  <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            shamt_q  <= shamt_d;
        end
    end
    assign busy       = state_q == SHIFT;
    assign done       = state_q == DONE;
    assign result     = result_q;
    assign shamt_used = shamt_q;
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed self-checking bench for shift_unit_seq
module tb_shift_unit_seq;
    logic        clk = 0, reset = 0, start = 0, start2 = 0;
    logic [1:0]  mode = 0, sel = 0, mode2 = 0, sel2 = 0;
    logic [14:0] amt_in = 0;
    logic [9:0]  amt_in2 = 0;
    logic [31:0] data_in = 0, data2 = 0;
    logic        busy, done, busy2, done2;
    logic [31:0] result, result2;
    logic [4:0]  shamt_used, shamt2;
    int          checks = 0, failures = 0;
    int          lat, nbusy, cnt;
    always #5 clk = ~clk;
    shift_unit_seq u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .sel(sel), .amt_in(amt_in),
        .data_in(data_in), .busy(busy), .done(done), .result(result), .shamt_used(shamt_used)
    );
    shift_unit_seq #(.N_SRC(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .sel(sel2), .amt_in(amt_in2),
        .data_in(data2), .busy(busy2), .done(done2), .result(result2), .shamt_used(shamt2)
    );
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_op(input logic [1:0] s, input logic [1:0] m, input logic [31:0] d);
        sel = s; mode = m; data_in = d; start = 1;
        tick();
        start = 0;
    endtask
    // Counts cycles from the current one until done, bounded.
    task automatic wait_done(output int l, output int nb);
        l = 0; nb = 0;
        while (!done && l < 200) begin
            if (busy) nb++;
            tick();
            l++;
        end
        if (!done) check("done_timeout", 32'(l), 32'hFFFF_FFFF);
    endtask
    initial begin
        // source2=1, source1=4, source0=0
        amt_in = {5'd1, 5'd4, 5'd0};
        tick(); tick();
        reset = 1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", result, 0);
        check("rst_shamt", 32'(shamt_used), 0);
        tick();
        start_op(2'd1, 2'b00, 32'h0000_00F1);
        wait_done(lat, nbusy);
        check("sll_lat", 32'(lat), 4);
        check("sll_busy", 32'(nbusy), 4);
        check("sll_result", result, 32'h0000_0F10);
        check("sll_shamt", 32'(shamt_used), 4);
        tick();
        check("sll_done_drop", 32'(done), 0);
        check("sll_hold", result, 32'h0000_0F10);
        start_op(2'd3, 2'b10, 32'h8000_1234);
        wait_done(lat, nbusy);
        check("sra_lat", 32'(lat), 16);
        check("sra_result", result, 32'hFFFF_8000);
        check("sra_shamt", 32'(shamt_used), 16);
        tick();
        start_op(2'd3, 2'b01, 32'h8000_1234);
        wait_done(lat, nbusy);
        check("srl_lat", 32'(lat), 16);
        check("srl_result", result, 32'h0000_8000);
        tick();
        start_op(2'd0, 2'b11, 32'hDEAD_BEEF);
        check("zero_busy", 32'(busy), 0);
        wait_done(lat, nbusy);
        check("zero_lat", 32'(lat), 0);
        check("zero_result", result, 32'hDEAD_BEEF);
        check("zero_shamt", 32'(shamt_used), 0);
        tick();
        sel2 = 2'd3; mode2 = 2'b11; data2 = 32'hDEAD_BEEF; amt_in2 = 10'h3FF; start2 = 1;
        tick();
        start2 = 0;
        check("n2_done", 32'(done2), 1);
        check("n2_busy", 32'(busy2), 0);
        check("n2_result", result2, 32'hDEAD_BEEF);
        check("n2_shamt", 32'(shamt2), 0);
        tick();
        check("n2_done_drop", 32'(done2), 0);
        start_op(2'd2, 2'b11, 32'h0000_0001);
        wait_done(lat, nbusy);
        check("ror_lat", 32'(lat), 1);
        check("ror_result", result, 32'h8000_0000);
        tick();
        // A start pulse during busy with new inputs must be ignored.
        start_op(2'd1, 2'b00, 32'h0000_00F1);
        sel = 2'd3; mode = 2'b01; data_in = 32'h1234_5678; start = 1;
        tick();
        start = 0;
        wait_done(lat, nbusy);
        check("ign_lat", 32'(lat + 1), 4);
        check("ign_result", result, 32'h0000_0F10);
        check("ign_shamt", 32'(shamt_used), 4);
        // Back-to-back: start asserted in the done cycle.
        start_op(2'd2, 2'b11, 32'h0000_0001);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done", 32'(done), 0);
        wait_done(lat, nbusy);
        check("b2b_lat", 32'(lat), 1);
        check("b2b_result", result, 32'h8000_0000);
        check("b2b_shamt", 32'(shamt_used), 1);
        tick();
        // Reset asserted in the 3rd SHIFT cycle.
        start_op(2'd3, 2'b10, 32'h8000_1234);
        tick(); tick();
        check("mid_busy_pre", 32'(busy), 1);
        reset = 0;
        tick();
        reset = 1;
        check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0);
        check("mid_result", result, 0);
        check("mid_shamt", 32'(shamt_used), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) cnt++;
            tick();
        end
        check("mid_quiet", 32'(cnt), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
